// File: rtl/encoder_pkg.sv
// Shared types for the encoder scan controller: scan conditions, FSM states
// and the per-channel condition decode.
package encoder_pkg;

  typedef enum logic [1:0] {NONE, INC, DEC, REL} cond_t;
  typedef enum logic [1:0] {SEL, SAMP, DEB, COMMIT} scan_state_t;

  // A released encoder input (sa high) only matters while its channel is holding.
  function automatic cond_t eval_cond(input logic sa, input logic sb, input logic hold);
    if (sa) return hold ? REL : NONE;
    if (hold) return NONE;
    return sb ? INC : DEC;
  endfunction

endpackage

// File: rtl/enc_sync2.sv
// Two-flop synchroniser for W asynchronous inputs; 2-cycle latency, no flow control.
module enc_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/encoder_scan_ctrl.sv
// Round-robin quadrature encoder scanner, one shared debounce counter; step accepted 2+2+DEBOUNCE+1 cycles after a stable input, no backpressure.
// Optional ENCODER_FRAME_LATCH_EN: pos becomes a shadow copy refreshed on frame_strobe.
module encoder_scan_ctrl
  import encoder_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int WIDTH    = 6,
  parameter int LIMIT    = 19,
  parameter int DEBOUNCE = 15000,
  localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       a,
  input  logic [NCH-1:0]       b,
  input  logic                 frame_strobe,
  output logic [NCH*WIDTH-1:0] pos,
  output logic                 evt,
  output logic [CHW-1:0]       evt_ch,
  output logic                 evt_dir
);

  localparam int CNTW = $clog2(DEBOUNCE + 1);

  logic [NCH-1:0]   sa;
  logic [NCH-1:0]   sb;
  scan_state_t      state, state_n;
  logic [CHW-1:0]   cur, cur_n;
  logic [CHW-1:0]   ptr, ptr_n;
  logic [CNTW-1:0]  cnt, cnt_n;
  cond_t            cond_q, cond_n;
  cond_t            cond_now;
  logic [WIDTH-1:0] pos_q [NCH];
  logic [NCH-1:0]   hold_q;
  logic [NCH*WIDTH-1:0] pos_flat;

  enc_sync2 #(.W(NCH)) u_sync_a (.clk(clk), .reset_n(reset_n), .d(a), .q(sa));
  enc_sync2 #(.W(NCH)) u_sync_b (.clk(clk), .reset_n(reset_n), .d(b), .q(sb));

  assign cond_now = eval_cond(sa[cur], sb[cur], hold_q[cur]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= SEL;
      cur    <= '0;
      ptr    <= '0;
      cnt    <= '0;
      cond_q <= NONE;
    end else begin
      state  <= state_n;
      cur    <= cur_n;
      ptr    <= ptr_n;
      cnt    <= cnt_n;
      cond_q <= cond_n;
    end
  end

  // ptr is the channel the next SEL picks, so scanning starts at channel 0 after reset.
  always_comb begin
    state_n = state;
    cur_n   = cur;
    ptr_n   = ptr;
    cnt_n   = cnt;
    cond_n  = cond_q;
    case (state)
      SEL: begin
        cur_n   = ptr;
        ptr_n   = (ptr == CHW'(NCH - 1)) ? '0 : ptr + 1'b1;
        state_n = SAMP;
      end
      SAMP: begin
        cond_n = cond_now;
        if (cond_now == NONE) begin
          state_n = SEL;
        end else begin
          cnt_n   = '0;
          state_n = DEB;
        end
      end
      DEB: begin
        if (cond_now != cond_q) begin
          cnt_n   = '0;
          state_n = SEL;
        end else if (cnt == CNTW'(DEBOUNCE - 1)) begin
          cnt_n   = '0;
          state_n = COMMIT;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      COMMIT:  state_n = SEL;
      default: state_n = SEL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) pos_q[i] <= '0;
      hold_q <= '0;
    end else if (state == COMMIT) begin
      case (cond_q)
        INC: begin
          if (pos_q[cur] < WIDTH'(LIMIT)) pos_q[cur] <= pos_q[cur] + 1'b1;
          hold_q[cur] <= 1'b1;
        end
        DEC: begin
          if (pos_q[cur] != '0) pos_q[cur] <= pos_q[cur] - 1'b1;
          hold_q[cur] <= 1'b1;
        end
        REL:     hold_q[cur] <= 1'b0;
        default: ;
      endcase
    end
  end

  // evt_ch/evt_dir keep the last accepted step; REL commits are silent.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt     <= 1'b0;
      evt_ch  <= '0;
      evt_dir <= 1'b0;
    end else if (state == COMMIT && (cond_q == INC || cond_q == DEC)) begin
      evt     <= 1'b1;
      evt_ch  <= cur;
      evt_dir <= (cond_q == INC);
    end else begin
      evt <= 1'b0;
    end
  end

  always_comb begin
    pos_flat = '0;
    for (int i = 0; i < NCH; i++) pos_flat[i*WIDTH +: WIDTH] = pos_q[i];
  end

`ifdef ENCODER_FRAME_LATCH_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          pos <= '0;
    else if (frame_strobe) pos <= pos_flat;
  end
`else
  logic unused_frame_strobe;
  assign unused_frame_strobe = frame_strobe;
  assign pos = pos_flat;
`endif

endmodule
